// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// IF stage of the 5-stage pipeline. Holds the PC, runs the instruction-memory
// request/acknowledge handshake and owns the IF/ID pipeline register.
//
// Instruction memory handshake:
//   imem_req is raised with a stable imem_addr and both are held until a cycle
//   in which imem_ack=1. imem_ack may arrive in the same cycle as the request
//   (zero latency). imem_data is only meaningful in the ack cycle. There is
//   never more than one request outstanding.
//
// States:
//   FETCH  : request to req_addr outstanding.
//   HOLD   : a response arrived during a stall. It is parked in the hold buffer
//            and no request is issued.
//   DRAIN  : a redirect hit an unacknowledged request. The old request is kept
//            on the bus until its ack arrives, and the data is thrown away.
//   HALTED : an HLT was delivered. Fetch stops until a redirect or reset.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc_wen, if_id_wen stall enables from the hazard unit (0 = hold)
//   redirect,
//   redirect_pc       branch taken / flush and its target
//   imem_req,
//   imem_addr         fetch request and address
//   imem_ack,
//   imem_data         response valid and instruction
//   if_id_instr,
//   if_id_pc_plus2,
//   if_id_valid       IF/ID pipeline register (valid=0 means bubble)
//   halted            fetch stopped on HLT
//   fsm_state         debug view of the fetch FSM state
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned      ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [15:0]      NOP_INSTR  = 16'h0000,
    parameter logic [3:0]       HLT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_wen,
    input  logic              if_id_wen,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic [15:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc_plus2,
    output logic              if_id_valid,
    output logic              halted,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       buf_instr;
    logic [ADDR_W-1:0] buf_pc_plus2;

    logic              adv;
    logic [ADDR_W-1:0] pc_plus2;
    logic              data_is_hlt;
    logic              buf_is_hlt;

    assign adv         = pc_wen & if_id_wen;
    // Natural wrap: 'hFFFE + 2 becomes 0.
    assign pc_plus2    = pc + ADDR_W'(2);
    assign data_is_hlt = (imem_data[15:12] == HLT_OPCODE);
    assign buf_is_hlt  = (buf_instr[15:12] == HLT_OPCODE);

    // Outputs decoded straight from the state register, so they carry no
    // combinational path from any input.
    assign imem_req  = (state == S_FETCH) || (state == S_DRAIN);
    assign imem_addr = req_addr;
    assign halted    = (state == S_HALTED);
    assign fsm_state = state;

    // req_addr is rewritten only on transitions that start a new request
    // (into FETCH). It is therefore frozen while a request waits for its ack,
    // including across redirects that send the FSM to DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_FETCH;
            pc             <= RESET_PC;
            req_addr       <= RESET_PC;
            buf_instr      <= NOP_INSTR;
            buf_pc_plus2   <= '0;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (redirect) begin
                        pc          <= redirect_pc;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        if (imem_ack) begin
                            // Response is for the squashed path; drop it.
                            req_addr <= redirect_pc;
                            state    <= S_FETCH;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        if (adv) begin
                            if_id_instr    <= imem_data;
                            if_id_pc_plus2 <= pc_plus2;
                            if_id_valid    <= 1'b1;
                            if (data_is_hlt) begin
                                state <= S_HALTED;
                            end else begin
                                pc       <= pc_plus2;
                                req_addr <= pc_plus2;
                            end
                        end else begin
                            buf_instr    <= imem_data;
                            buf_pc_plus2 <= pc_plus2;
                            state        <= S_HOLD;
                        end
                    end else if (if_id_wen) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        pc           <= redirect_pc;
                        req_addr     <= redirect_pc;
                        if_id_instr  <= NOP_INSTR;
                        if_id_valid  <= 1'b0;
                        buf_instr    <= NOP_INSTR;
                        buf_pc_plus2 <= '0;
                        state        <= S_FETCH;
                    end else if (adv) begin
                        if_id_instr    <= buf_instr;
                        if_id_pc_plus2 <= buf_pc_plus2;
                        if_id_valid    <= 1'b1;
                        buf_instr      <= NOP_INSTR;
                        buf_pc_plus2   <= '0;
                        if (buf_is_hlt) begin
                            state <= S_HALTED;
                        end else begin
                            pc       <= buf_pc_plus2;
                            req_addr <= buf_pc_plus2;
                            state    <= S_FETCH;
                        end
                    end
                end

                S_DRAIN: begin
                    if (redirect) begin
                        pc          <= redirect_pc;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end else if (if_id_wen) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end
                    if (imem_ack) begin
                        // Stale data discarded; restart at the newest target.
                        req_addr <= redirect ? redirect_pc : pc;
                        state    <= S_FETCH;
                    end
                end

                S_HALTED: begin
                    if (redirect) begin
                        pc          <= redirect_pc;
                        req_addr    <= redirect_pc;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        state       <= S_FETCH;
                    end else if (if_id_wen) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A small instruction-memory model answers
// requests after a programmable number of wait cycles (lat). Inputs are driven
// 1 time unit after the rising edge; outputs are checked at that point too
// (registered results of the previous edge, and combinational request outputs).
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int unsigned ADDR_W = 16;

    logic              clk;
    logic              rst_n;
    logic              pc_wen;
    logic              if_id_wen;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_data;
    logic [15:0]       if_id_instr;
    logic [ADDR_W-1:0] if_id_pc_plus2;
    logic              if_id_valid;
    logic              halted;
    logic [1:0]        fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------------------------------------------------------- clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT
    fetch_stage #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000),
        .HLT_OPCODE(4'hF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_wen        (pc_wen),
        .if_id_wen     (if_id_wen),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus2(if_id_pc_plus2),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .fsm_state     (fsm_state)
    );

    // ---------------------------------------------------------------- memory model
    int unsigned lat;
    int unsigned wait_cnt;
    logic        ack_force;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h0000: mem_rd = 16'h1123;
            16'h0002: mem_rd = 16'h2234;
            16'h0004: mem_rd = 16'h3345;
            16'h0006: mem_rd = 16'h4456;
            16'h0008: mem_rd = 16'h5567;
            16'h000A: mem_rd = 16'hF000;
            16'h0020: mem_rd = 16'h9999;
            16'h0040: mem_rd = 16'h7777;
            16'h0100: mem_rd = 16'h8888;
            default:  mem_rd = {4'h1, a[11:0]};
        endcase
    endfunction

    assign imem_ack  = imem_req && ((wait_cnt >= lat) || ack_force);
    assign imem_data = mem_rd(imem_addr);

    always @(posedge clk) begin
        if (!rst_n || !imem_req || imem_ack) wait_cnt <= 0;
        else                                 wait_cnt <= wait_cnt + 1;
    end

    // ---------------------------------------------------------------- checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected IF/ID contents checked as a unit.
    task automatic check_if_id(input string tag, input logic [15:0] instr,
                               input logic [15:0] pc2, input logic vld);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, vld});
        if (vld) begin
            check({tag, ".instr"}, {16'd0, if_id_instr}, {16'd0, instr});
            check({tag, ".pc_plus2"}, {16'd0, if_id_pc_plus2}, {16'd0, pc2});
        end else begin
            check({tag, ".nop"}, {16'd0, if_id_instr}, 32'h0000);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst_n       = 1'b0;
        pc_wen      = 1'b1;
        if_id_wen   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        lat         = 0;
        ack_force   = 1'b0;

        #2;
        check("rst.valid",  {31'd0, if_id_valid}, 32'd0);
        check("rst.instr",  {16'd0, if_id_instr}, 32'h0000);
        check("rst.pc2",    {16'd0, if_id_pc_plus2}, 32'h0000);
        check("rst.halted", {31'd0, halted}, 32'd0);
        check("rst.req",    {31'd0, imem_req}, 32'd1);
        check("rst.addr",   {16'd0, imem_addr}, 32'h0000);

        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("t1.req0",  {31'd0, imem_req}, 32'd1);
        check("t1.addr0", {16'd0, imem_addr}, 32'h0000);

        // 1: zero-latency back-to-back fetch
        tick();
        check_if_id("t1.c1", 16'h1123, 16'h0002, 1'b1);
        check("t1.addr2", {16'd0, imem_addr}, 32'h0002);
        tick();
        check_if_id("t1.c2", 16'h2234, 16'h0004, 1'b1);
        check("t1.addr4", {16'd0, imem_addr}, 32'h0004);

        // 2: one-cycle stall while the instruction at 4 is acked
        pc_wen = 1'b0; if_id_wen = 1'b0;
        tick();
        check_if_id("t2.hold", 16'h2234, 16'h0004, 1'b1);
        check("t2.req", {31'd0, imem_req}, 32'd0);
        pc_wen = 1'b1; if_id_wen = 1'b1;
        tick();
        check_if_id("t2.buf", 16'h3345, 16'h0006, 1'b1);
        check("t2.addr6", {16'd0, imem_addr}, 32'h0006);
        tick();
        check_if_id("t2.next", 16'h4456, 16'h0008, 1'b1);
        check("t2.addr8", {16'd0, imem_addr}, 32'h0008);

        // 3: 3-cycle latency, redirect in the 2nd wait cycle of the fetch at 8
        lat = 3;
        tick();
        check_if_id("t3.w1", 16'h0000, 16'h0000, 1'b0);
        check("t3.addr_w1", {16'd0, imem_addr}, 32'h0008);
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check_if_id("t3.w2", 16'h0000, 16'h0000, 1'b0);
        check("t3.addr_w2", {16'd0, imem_addr}, 32'h0008);
        check("t3.req_w2",  {31'd0, imem_req}, 32'd1);
        tick();
        check_if_id("t3.w3", 16'h0000, 16'h0000, 1'b0);
        check("t3.addr_w3", {16'd0, imem_addr}, 32'h0008);
        tick();
        check_if_id("t3.drop", 16'h0000, 16'h0000, 1'b0);
        check("t3.addr40", {16'd0, imem_addr}, 32'h0040);
        lat = 0;
        tick();
        check_if_id("t3.f40", 16'h7777, 16'h0042, 1'b1);

        // 4: redirect, stall and ack in the same cycle
        pc_wen = 1'b0; if_id_wen = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0; pc_wen = 1'b1; if_id_wen = 1'b1;
        check_if_id("t4.flush", 16'h0000, 16'h0000, 1'b0);
        check("t4.addr100", {16'd0, imem_addr}, 32'h0100);
        check("t4.req",     {31'd0, imem_req}, 32'd1);
        tick();
        check_if_id("t4.f100", 16'h8888, 16'h0102, 1'b1);

        // 5: HLT at 0x000A, then redirect out of halt
        redirect = 1'b1; redirect_pc = 16'h000A;
        tick();
        redirect = 1'b0;
        check_if_id("t5.flush", 16'h0000, 16'h0000, 1'b0);
        check("t5.addrA", {16'd0, imem_addr}, 32'h000A);
        tick();
        check_if_id("t5.hlt", 16'hF000, 16'h000C, 1'b1);
        check("t5.halted", {31'd0, halted}, 32'd1);
        check("t5.req",    {31'd0, imem_req}, 32'd0);
        tick();
        check_if_id("t5.bubble", 16'h0000, 16'h0000, 1'b0);
        check("t5.halted2", {31'd0, halted}, 32'd1);
        check("t5.req2",    {31'd0, imem_req}, 32'd0);
        redirect = 1'b1; redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        check("t5.unhalt", {31'd0, halted}, 32'd0);
        check("t5.addr20", {16'd0, imem_addr}, 32'h0020);
        check("t5.req3",   {31'd0, imem_req}, 32'd1);
        tick();
        check_if_id("t5.f20", 16'h9999, 16'h0022, 1'b1);

        // 6: PC wrap at 0xFFFE, then reset in the middle of a wait
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        check("t6.addrFFFE", {16'd0, imem_addr}, 32'hFFFE);
        tick();
        check_if_id("t6.wrap", 16'h1FFE, 16'h0000, 1'b1);
        check("t6.addr0", {16'd0, imem_addr}, 32'h0000);
        tick();
        check_if_id("t6.f0", 16'h1123, 16'h0002, 1'b1);
        check("t6.addr2", {16'd0, imem_addr}, 32'h0002);
        lat = 3; if_id_wen = 1'b0;
        tick();
        check_if_id("t6.wait", 16'h1123, 16'h0002, 1'b1);
        check("t6.addr_wait", {16'd0, imem_addr}, 32'h0002);
        #2 rst_n = 1'b0; ack_force = 1'b1;
        #1;
        check_if_id("t6.arst", 16'h0000, 16'h0000, 1'b0);
        check("t6.arst.addr",   {16'd0, imem_addr}, 32'h0000);
        check("t6.arst.halted", {31'd0, halted}, 32'd0);
        tick();
        tick();
        check_if_id("t6.late_ack", 16'h0000, 16'h0000, 1'b0);
        check("t6.late_ack.addr", {16'd0, imem_addr}, 32'h0000);
        ack_force = 1'b0; lat = 0; if_id_wen = 1'b1;
        #3 rst_n = 1'b1;
        #1;
        check("t6.rel.req",  {31'd0, imem_req}, 32'd1);
        check("t6.rel.addr", {16'd0, imem_addr}, 32'h0000);
        tick();
        check_if_id("t6.rel.f0", 16'h1123, 16'h0002, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
